// File: rtl/fib_pkg.sv
// Shared parameters and FSM state encodings for the Fibonacci stack engine.
// Optional build macro: FIB_SATURATE_EN (saturating result instead of wrap).
package fib_pkg;

    localparam int ENTRY_W     = 4;
    localparam int RES_W       = 8;
    localparam int STACK_DEPTH = 16;
    // One extra bit so the pointer can represent "full" as well as "empty".
    localparam int SP_W        = $clog2(STACK_DEPTH) + 1;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INIT  = 3'd1;
    localparam logic [2:0] ST_POP   = 3'd2;
    localparam logic [2:0] ST_EVAL  = 3'd3;
    localparam logic [2:0] ST_PUSH2 = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/fib_stack_engine_if.sv
// Command/result bundle of the Fibonacci stack engine.
// Handshake: the master holds start=1 while the engine is in IDLE or DONE to
// launch one computation with the current entry; entry is captured once, in
// the INIT cycle. done=1 (held in DONE) marks result as valid and stable;
// start and entry are ignored while the engine is busy.
// state is a read-only debug view of the controller FSM.
interface fib_stack_engine_if;

    logic                         start;
    logic [fib_pkg::ENTRY_W-1:0]  entry;
    logic [fib_pkg::RES_W-1:0]    result;
    logic                         done;
    logic [2:0]                   state;

    modport master (output start, entry, input result, done, state);
    modport slave  (input start, entry, output result, done, state);

endinterface

// File: rtl/fib_stack_engine_ctrl.sv
// Controller FSM: walks the recursive call tree one stack operation per cycle
// and issues datapath strobes (init, pop, push cur-1, push cur-2, accumulate).
module fib_stack_engine_ctrl
    import fib_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       backtrack,   // stack empty
    input  logic       cal_update,  // cur < 2, i.e. a leaf
    output logic       load_init,
    output logic       poping,
    output logic       updater,     // push cur-1
    output logic       alu,         // push cur-2
    output logic       cal_res,     // add leaf value into result
    output logic       done,
    output logic [2:0] state
);

    logic [2:0] state_q;
    logic [2:0] state_d;

    assign state = state_q;

    // State register with asynchronous abort to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state and one-hot strobe decode.
    always_comb begin
        state_d   = state_q;
        load_init = 1'b0;
        poping    = 1'b0;
        updater   = 1'b0;
        alu       = 1'b0;
        cal_res   = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_INIT;
            end
            ST_INIT: begin
                load_init = 1'b1;
                state_d   = ST_POP;
            end
            ST_POP: begin
                poping  = 1'b1;
                state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (cal_update) begin
                    cal_res = 1'b1;
                    state_d = backtrack ? ST_DONE : ST_POP;
                end else begin
                    updater = 1'b1;
                    state_d = ST_PUSH2;
                end
            end
            ST_PUSH2: begin
                alu     = 1'b1;
                state_d = ST_POP;
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) state_d = ST_INIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/fib_stack_engine.sv
// Fibonacci engine top: result = Fib(entry) computed by emulating the
// recursive call tree with an explicit LIFO. Hosts the datapath (stack,
// stack pointer, current node, accumulator) and the controller.
// Optional build macro: FIB_SATURATE_EN clamps result at all-ones instead of
// wrapping modulo 2**RES_W.
module fib_stack_engine
    import fib_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    fib_stack_engine_if.slave   bus
);

    logic               load_init;
    logic               poping;
    logic               updater;
    logic               alu;
    logic               cal_res;
    logic               backtrack;
    logic               cal_update;

    logic [ENTRY_W-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-1:0]    sp;
    logic [ENTRY_W-1:0] cur;
    logic [RES_W-1:0]   result_q;
    logic [RES_W-1:0]   sum;
    logic [ENTRY_W-1:0] push_data;
    logic [SP_W-2:0]    wr_idx;
    logic [SP_W-2:0]    top_idx;

    fib_stack_engine_ctrl u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .start      (bus.start),
        .backtrack  (backtrack),
        .cal_update (cal_update),
        .load_init  (load_init),
        .poping     (poping),
        .updater    (updater),
        .alu        (alu),
        .cal_res    (cal_res),
        .done       (bus.done),
        .state      (bus.state)
    );

    assign backtrack  = (sp == '0);
    assign cal_update = (cur < ENTRY_W'(2));
    assign bus.result = result_q;

    // INIT restarts the stack, so its push always lands in slot 0.
    assign wr_idx  = load_init ? '0 : sp[SP_W-2:0];
    assign top_idx = sp[SP_W-2:0] - (SP_W-1)'(1);

    // Operand for the current push: the argument, or one of the two children.
    always_comb begin
        push_data = bus.entry;
        if (updater)  push_data = cur - ENTRY_W'(1);
        else if (alu) push_data = cur - ENTRY_W'(2);
    end

    // Leaf accumulation, either wrapping or clamping on overflow.
`ifdef FIB_SATURATE_EN
    logic [RES_W:0] sum_w;
    always_comb begin
        sum_w = {1'b0, result_q} + (RES_W+1)'(cur);
        sum   = sum_w[RES_W] ? '1 : sum_w[RES_W-1:0];
    end
`else
    always_comb begin
        sum = result_q + RES_W'(cur);
    end
`endif

    // Stack storage: plain memory, only the pointer needs reset.
    always_ff @(posedge clk) begin
        if (load_init || updater || alu) stack_mem[wr_idx] <= push_data;
    end

    // Stack pointer, current node and accumulator.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp       <= '0;
            cur      <= '0;
            result_q <= '0;
        end else begin
            if (load_init) begin
                sp       <= SP_W'(1);
                result_q <= '0;
            end else if (poping) begin
                sp  <= sp - SP_W'(1);
                cur <= stack_mem[top_idx];
            end else if (updater || alu) begin
                sp <= sp + SP_W'(1);
            end
            if (cal_res) result_q <= sum;
        end
    end

endmodule

// File: tb/tb_fib_stack_engine.sv
// Directed bench for fib_stack_engine: expected results and latencies are
// queued at launch and popped when done rises.
module tb_fib_stack_engine;
    import fib_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [RES_W-1:0] exp_q[$];
    int               lat_q[$];

    fib_stack_engine_if bus ();

    fib_stack_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fib_int(input int n);
        int a;
        int b;
        int t;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic logic [RES_W-1:0] fib_exp(input int n);
        int f;
        f = fib_int(n);
`ifdef FIB_SATURATE_EN
        if (f > (1 << RES_W) - 1) f = (1 << RES_W) - 1;
`endif
        return RES_W'(f % (1 << RES_W));
    endfunction

    function automatic int lat_exp(input int n);
        int leaves;
        if (n == 0) return 3;
        leaves = fib_int(n + 1);
        return 1 + 2 * leaves + 3 * (leaves - 1);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Launch one computation (from IDLE or DONE) and score it on completion.
    task automatic run(input int n, input bit disturb);
        int cycles;
        logic [RES_W-1:0] held;
        @(negedge clk);
        bus.entry = ENTRY_W'(n);
        bus.start = 1'b1;
        exp_q.push_back(fib_exp(n));
        lat_q.push_back(lat_exp(n));
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        check($sformatf("init_state_n%0d", n), int'(bus.state), int'(ST_INIT));
        check($sformatf("init_done_n%0d", n), int'(bus.done), 0);
        cycles = 0;
        while (cycles < 5000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (bus.done) break;
            if (disturb) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.entry = ENTRY_W'($urandom_range(0, 15));
            end
        end
        bus.start = 1'b0;
        check($sformatf("done_seen_n%0d", n), int'(bus.done), 1);
        check($sformatf("result_n%0d", n), int'(bus.result), int'(exp_q.pop_front()));
        check($sformatf("latency_n%0d", n), cycles, lat_q.pop_front());
        held = bus.result;
        @(posedge clk);
        @(negedge clk);
        check($sformatf("hold_done_n%0d", n), int'(bus.done), 1);
        check($sformatf("hold_result_n%0d", n), int'(bus.result), int'(held));
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.entry = '0;
        #1;
        check("reset_result", int'(bus.result), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_state", int'(bus.state), int'(ST_IDLE));
        repeat (2) @(negedge clk);
        rst = 1'b1;

        run(6, 1'b0);
        run(0, 1'b0);
        run(1, 1'b0);
        run(13, 1'b0);
        run(14, 1'b0);
        run(5, 1'b0);   // restart straight from DONE

        // Abort mid-computation with asynchronous reset
        @(negedge clk);
        bus.entry = ENTRY_W'(10);
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("busy_before_abort", int'(bus.state == ST_IDLE || bus.state == ST_DONE), 0);
        rst = 1'b0;
        #1;
        check("abort_result", int'(bus.result), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_state", int'(bus.state), int'(ST_IDLE));
        @(negedge clk);
        rst = 1'b1;
        run(10, 1'b0);

        run(7, 1'b1);   // start/entry toggled while busy

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
